alignment_unit: RTL and testbench

Pre-add operand alignment stage of the 32-bit floating-point adder, the counterpart to the post-add normalizing unit. It takes two unpacked operands (8-bit biased exponent, 24-bit mantissa with explicit hidden bit), orders them by magnitude, and right-shifts the smaller mantissa by the exponent difference, one bit per cycle. It produces guard, round and sticky bits and a common exponent for the mantissa adder. An enable/busy/done handshake sequences it with the adder control.

---
 rtl/alignment_unit_if.sv | 29 ++
 rtl/alignment_unit.sv | 107 ++++++++++
 tb/tb_alignment_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/alignment_unit_if.sv
// rtl/alignment_unit_if.sv - operand/result bundle for the FP adder alignment stage
interface alignment_unit_if;
  logic        enable;
  logic [7:0]  a_exponent;
  logic [23:0] a_mantissa;
  logic [7:0]  b_exponent;
  logic [23:0] b_mantissa;
  logic [23:0] mantissa_large;
  logic [23:0] mantissa_aligned;
  logic        guard;
  logic        round;
  logic        sticky;
  logic [7:0]  exponent_common;
  logic        swapped;
  logic        busy;
  logic        done;

  modport master (
    output enable, a_exponent, a_mantissa, b_exponent, b_mantissa,
    input  mantissa_large, mantissa_aligned, guard, round, sticky,
           exponent_common, swapped, busy, done
  );

  modport slave (
    input  enable, a_exponent, a_mantissa, b_exponent, b_mantissa,
    output mantissa_large, mantissa_aligned, guard, round, sticky,
           exponent_common, swapped, busy, done
  );
endinterface

// File: rtl/alignment_unit.sv
// rtl/alignment_unit.sv - pre-add operand alignment: magnitude ordering and iterative right shift
module alignment_unit #(
  parameter int MAX_SHIFT = 26
) (
  input logic              Clk,
  input logic              Reset,
  alignment_unit_if.slave  bus
);
  localparam logic [7:0] MAX_SHIFT_W = 8'(MAX_SHIFT);

  typedef enum logic [1:0] {IDLE, CMP, SHIFT, DONE} state_t;

  state_t      state, state_next;
  logic [7:0]  a_exp_q, b_exp_q;
  logic [23:0] a_man_q, b_man_q;
  logic [7:0]  count;

  logic [23:0] mantissa_large_q, mantissa_aligned_q;
  logic        guard_q, round_q, sticky_q, swapped_q;
  logic [7:0]  exponent_common_q;

  logic        a_larger;
  logic [7:0]  exp_large, exp_small, diff;
  logic [23:0] man_large, man_small;

  always_comb begin
    a_larger  = (a_exp_q > b_exp_q) || ((a_exp_q == b_exp_q) && (a_man_q >= b_man_q));
    exp_large = a_larger ? a_exp_q : b_exp_q;
    exp_small = a_larger ? b_exp_q : a_exp_q;
    man_large = a_larger ? a_man_q : b_man_q;
    man_small = a_larger ? b_man_q : a_man_q;
    diff      = exp_large - exp_small;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.enable) state_next = CMP;
      CMP:     state_next = ((diff == 8'd0) || (diff > MAX_SHIFT_W)) ? DONE : SHIFT;
      SHIFT:   if (count == 8'd1) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state              <= IDLE;
      a_exp_q            <= '0;
      b_exp_q            <= '0;
      a_man_q            <= '0;
      b_man_q            <= '0;
      count              <= '0;
      mantissa_large_q   <= '0;
      mantissa_aligned_q <= '0;
      guard_q            <= 1'b0;
      round_q            <= 1'b0;
      sticky_q           <= 1'b0;
      swapped_q          <= 1'b0;
      exponent_common_q  <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (bus.enable) begin
            a_exp_q <= bus.a_exponent;
            a_man_q <= bus.a_mantissa;
            b_exp_q <= bus.b_exponent;
            b_man_q <= bus.b_mantissa;
          end
        end
        CMP: begin
          mantissa_large_q  <= man_large;
          exponent_common_q <= exp_large;
          swapped_q         <= ~a_larger;
          guard_q           <= 1'b0;
          round_q           <= 1'b0;
          count             <= diff;
          // Beyond MAX_SHIFT every mantissa bit lands past round, so collapse into sticky.
          if (diff > MAX_SHIFT_W) begin
            mantissa_aligned_q <= '0;
            sticky_q           <= |man_small;
          end else begin
            mantissa_aligned_q <= man_small;
            sticky_q           <= 1'b0;
          end
        end
        SHIFT: begin
          {mantissa_aligned_q, guard_q, round_q} <= {1'b0, mantissa_aligned_q, guard_q};
          sticky_q <= sticky_q | round_q;
          count    <= count - 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.mantissa_large   = mantissa_large_q;
  assign bus.mantissa_aligned = mantissa_aligned_q;
  assign bus.guard            = guard_q;
  assign bus.round            = round_q;
  assign bus.sticky           = sticky_q;
  assign bus.exponent_common  = exponent_common_q;
  assign bus.swapped          = swapped_q;
  assign bus.busy             = (state == CMP) || (state == SHIFT);
  assign bus.done             = (state == DONE);
endmodule

// File: tb/tb_alignment_unit.sv
// tb/tb_alignment_unit.sv - randomized self-checking bench for alignment_unit
module tb_alignment_unit;
  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  alignment_unit_if bus ();

  alignment_unit #(.MAX_SHIFT(26)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact right shift of the smaller mantissa in a wide word, then slice.
  task automatic model(input logic [7:0] ae, input logic [23:0] am,
                       input logic [7:0] be, input logic [23:0] bm,
                       output logic [23:0] ml, output logic [23:0] al,
                       output logic g, output logic r, output logic s,
                       output logic [7:0] ec, output logic sw, output int d);
    logic [63:0] ext;
    logic [23:0] sm;
    int diff;
    sw   = !((ae > be) || ((ae == be) && (am >= bm)));
    ml   = sw ? bm : am;
    sm   = sw ? am : bm;
    ec   = sw ? be : ae;
    diff = sw ? (int'(be) - int'(ae)) : (int'(ae) - int'(be));
    if (diff > 26) begin
      al = '0; g = 1'b0; r = 1'b0; s = |sm; d = 0;
    end else begin
      ext = {sm, 40'd0} >> diff;
      al  = ext[63:40];
      g   = ext[39];
      r   = ext[38];
      s   = |ext[37:0];
      d   = diff;
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return {2'b00, bus.mantissa_large, bus.mantissa_aligned, bus.guard, bus.round,
            bus.sticky, bus.exponent_common, bus.swapped, bus.busy, bus.done};
  endfunction

  task automatic run_op(input string tag, input logic [7:0] ae, input logic [23:0] am,
                        input logic [7:0] be, input logic [23:0] bm, input bit poke);
    logic [23:0] ml, al;
    logic g, r, s, sw;
    logic [7:0] ec;
    int d, n;
    bit seen;
    model(ae, am, be, bm, ml, al, g, r, s, ec, sw, d);
    @(negedge Clk);
    bus.a_exponent = ae; bus.a_mantissa = am;
    bus.b_exponent = be; bus.b_mantissa = bm;
    bus.enable = 1'b1;
    @(posedge Clk);
    #1 bus.enable = 1'b0;
    n = 0;
    seen = 1'b0;
    while (n < 40) begin
      @(negedge Clk);
      bus.enable = 1'b0;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      check({tag, " busy"}, 64'(bus.busy), 64'd1);
      if (poke) begin
        bus.enable     = 1'b1;
        bus.a_exponent = 8'($urandom);
        bus.a_mantissa = 24'($urandom);
        bus.b_exponent = 8'($urandom);
        bus.b_mantissa = 24'($urandom);
      end
      @(posedge Clk);
      n++;
    end
    check({tag, " done_seen"}, 64'(seen), 64'd1);
    check({tag, " latency"}, 64'(n), 64'(1 + d));
    check({tag, " busy_in_done"}, 64'(bus.busy), 64'd0);
    check({tag, " results"},
          {18'd0, ml, al, g, r, s, ec, sw},
          {18'd0, bus.mantissa_large, bus.mantissa_aligned, bus.guard, bus.round,
           bus.sticky, bus.exponent_common, bus.swapped});
    @(negedge Clk);
    check({tag, " done_one_cycle"}, 64'(bus.done), 64'd0);
    check({tag, " hold"}, {40'd0, bus.mantissa_aligned}, {40'd0, al});
  endtask

  initial begin
    bit pulsed;
    logic [7:0] ae, be;
    logic [23:0] am, bm;

    bus.enable = 1'b0;
    bus.a_exponent = '0; bus.a_mantissa = '0;
    bus.b_exponent = '0; bus.b_mantissa = '0;

    // Reset held with enable asserted
    Reset = 1'b1;
    bus.enable = 1'b1;
    bus.a_exponent = 8'd130; bus.a_mantissa = 24'hC00000;
    bus.b_exponent = 8'd127; bus.b_mantissa = 24'h800000;
    pulsed = 1'b0;
    repeat (2) begin
      @(negedge Clk);
      pulsed |= bus.done;
    end
    check("reset outputs", all_outputs(), 64'd0);
    check("reset no_done", 64'(pulsed), 64'd0);
    bus.enable = 1'b0;
    Reset = 1'b0;

    run_op("a_larger_d3",  8'd130, 24'hC00000, 8'd127, 24'h800000, 1'b0);
    run_op("b_larger_rnd", 8'd100, 24'h800001, 8'd102, 24'h800000, 1'b0);
    run_op("equal_exp",    8'd127, 24'h900000, 8'd127, 24'hA00000, 1'b0);
    run_op("clamp",        8'd200, 24'h800000, 8'd30,  24'h800001, 1'b0);
    run_op("boundary_26",  8'd153, 24'h800000, 8'd127, 24'hFFFFFF, 1'b0);
    run_op("poke_26",      8'd153, 24'h800000, 8'd127, 24'hFFFFFF, 1'b1);
    run_op("boundary_27",  8'd154, 24'h800000, 8'd127, 24'hFFFFFF, 1'b0);
    run_op("equal_all",    8'd90,  24'hABCDEF, 8'd90,  24'hABCDEF, 1'b0);

    // Abort with reset at edge k+10
    @(negedge Clk);
    bus.a_exponent = 8'd153; bus.a_mantissa = 24'h800000;
    bus.b_exponent = 8'd127; bus.b_mantissa = 24'hFFFFFF;
    bus.enable = 1'b1;
    @(posedge Clk);
    #1 bus.enable = 1'b0;
    repeat (9) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    check("abort outputs", all_outputs(), 64'd0);
    Reset = 1'b0;
    pulsed = 1'b0;
    repeat (35) begin
      @(negedge Clk);
      pulsed |= bus.done;
    end
    check("abort no_done", 64'(pulsed), 64'd0);

    for (int i = 0; i < 40; i++) begin
      ae = 8'($urandom_range(1, 254));
      case ($urandom_range(0, 3))
        0:       be = ae;
        1:       be = 8'(int'(ae) + $urandom_range(0, 30));
        2:       be = 8'(int'(ae) - $urandom_range(0, 30));
        default: be = 8'($urandom);
      endcase
      am = {1'b1, 23'($urandom)};
      bm = ($urandom_range(0, 7) == 0) ? am : {1'b1, 23'($urandom)};
      run_op($sformatf("rand%0d", i), ae, am, be, bm, bit'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
